// File: rtl/pc_gen.sv
// pc_gen: parametrised fetch-stage program-counter generator.
// Has prioritised redirect sources, a valid/ready fetch handshake, a one-entry
// pending-redirect buffer that holds redirects arriving while stalled or halted,
// and a BOOT -> RUN <-> HALTED state machine.
//
// Fetch handshake: while fetch_valid is high, pc_o is a fetch request; it is
// consumed on a rising edge where fetch_ready is also high. An unaccepted pc_o
// stays stable, unless a redirect replaces it (the unaccepted fetch is dropped).
module pc_gen #(
    parameter int                 ADDR_W      = 32,
    parameter logic [ADDR_W-1:0]  RESET_ADDR  = '0,
    parameter int                 STEP        = 1,
    parameter int                 NUM_REDIR   = 3,
    parameter int                 BOOT_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REDIR-1:0]          redir_valid,
    input  logic [NUM_REDIR*ADDR_W-1:0]   redir_addr,
    input  logic                          stall,
    input  logic                          halt_req,
    input  logic                          resume,
    input  logic                          fetch_ready,
    output logic                          fetch_valid,
    output logic [ADDR_W-1:0]             pc_o,
    output logic                          redir_taken,
    output logic                          halted
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // Boot counter value on which the FSM leaves BOOT.
    localparam logic [3:0]        BOOT_LAST = 4'(BOOT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] STEP_VAL  = ADDR_W'(STEP);

    state_t              state,      state_nxt;
    logic [3:0]          boot_cnt,   boot_cnt_nxt;
    logic [ADDR_W-1:0]   pc,         pc_nxt;
    logic                pend_valid, pend_valid_nxt;
    logic [ADDR_W-1:0]   pend_addr,  pend_addr_nxt;
    logic                taken,      taken_nxt;

    logic                have_redir;
    logic [ADDR_W-1:0]   sel_addr;

    // Priority select: scanning from the top down lets the lowest index win.
    always_comb begin
        have_redir = 1'b0;
        sel_addr   = '0;
        for (int i = NUM_REDIR - 1; i >= 0; i--) begin
            if (redir_valid[i]) begin
                have_redir = 1'b1;
                sel_addr   = redir_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Next-state, next-PC and pending-buffer decisions.
    always_comb begin
        state_nxt      = state;
        boot_cnt_nxt   = boot_cnt;
        pc_nxt         = pc;
        pend_valid_nxt = pend_valid;
        pend_addr_nxt  = pend_addr;
        taken_nxt      = 1'b0;

        unique case (state)
            ST_BOOT: begin
                // Redirects, stall and halt_req are all ignored while booting.
                if (boot_cnt == BOOT_LAST) begin
                    state_nxt = ST_RUN;
                end else begin
                    boot_cnt_nxt = boot_cnt + 4'd1;
                end
            end

            ST_RUN: begin
                if (have_redir && !stall) begin
                    pc_nxt         = sel_addr;
                    pend_valid_nxt = 1'b0;
                    taken_nxt      = 1'b1;
                end else if (have_redir) begin
                    // Newest redirect overwrites any older pending one.
                    pend_valid_nxt = 1'b1;
                    pend_addr_nxt  = sel_addr;
                end else if (!stall && pend_valid) begin
                    pc_nxt         = pend_addr;
                    pend_valid_nxt = 1'b0;
                    taken_nxt      = 1'b1;
                end else if (!stall && fetch_ready) begin
                    pc_nxt = pc + STEP_VAL;
                end
                // The PC rules above still apply on the edge that enters HALTED.
                if (halt_req) begin
                    state_nxt = ST_HALTED;
                end
            end

            ST_HALTED: begin
                if (resume) begin
                    state_nxt = ST_RUN;
                    if (have_redir) begin
                        pc_nxt         = sel_addr;
                        pend_valid_nxt = 1'b0;
                        taken_nxt      = 1'b1;
                    end else if (pend_valid) begin
                        pc_nxt         = pend_addr;
                        pend_valid_nxt = 1'b0;
                        taken_nxt      = 1'b1;
                    end
                end else if (have_redir) begin
                    pend_valid_nxt = 1'b1;
                    pend_addr_nxt  = sel_addr;
                end
            end

            default: begin
                state_nxt = ST_BOOT;
            end
        endcase
    end

    // State register; reset aborts immediately and discards any pending redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_BOOT;
            boot_cnt   <= 4'd0;
            pc         <= RESET_ADDR;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            taken      <= 1'b0;
        end else begin
            state      <= state_nxt;
            boot_cnt   <= boot_cnt_nxt;
            pc         <= pc_nxt;
            pend_valid <= pend_valid_nxt;
            pend_addr  <= pend_addr_nxt;
            taken      <= taken_nxt;
        end
    end

    assign pc_o        = pc;
    assign redir_taken = taken;
    assign fetch_valid = (state == ST_RUN);
    assign halted      = (state == ST_HALTED);

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scenarios plus randomized traffic checked against a
// behavioural reference model of the PC generator.
module tb_pc_gen;

    localparam int W     = 32;
    localparam int NR    = 3;
    localparam int BOOT  = 2;
    localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // main DUT (default parameters)
    logic [NR-1:0]   redir_valid = '0;
    logic [NR*W-1:0] redir_addr  = '0;
    logic stall = 0, halt_req = 0, resume = 0, fetch_ready = 0;
    logic fetch_valid, redir_taken, halted;
    logic [W-1:0] pc_o;

    pc_gen dut (
        .clk(clk), .rst(rst), .redir_valid(redir_valid), .redir_addr(redir_addr),
        .stall(stall), .halt_req(halt_req), .resume(resume), .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid), .pc_o(pc_o), .redir_taken(redir_taken), .halted(halted)
    );

    // narrow byte-addressed DUT for the wrap-around case
    logic [NR-1:0]   r8_valid = '0;
    logic [NR*8-1:0] r8_addr  = '0;
    logic stall8 = 0, halt8 = 0, resume8 = 0, ready8 = 0;
    logic fv8, taken8, halted8;
    logic [7:0] pc8;

    pc_gen #(.ADDR_W(8), .RESET_ADDR(8'h00), .STEP(4)) dut8 (
        .clk(clk), .rst(rst), .redir_valid(r8_valid), .redir_addr(r8_addr),
        .stall(stall8), .halt_req(halt8), .resume(resume8), .fetch_ready(ready8),
        .fetch_valid(fv8), .pc_o(pc8), .redir_taken(taken8), .halted(halted8)
    );

    int n_vec = 0;
    int n_err = 0;

    // reference model state (main DUT)
    int           m_mode;
    int           m_boot_left;
    logic [W-1:0] m_pc;
    logic [W-1:0] m_pend[$];
    logic         m_taken;

    task automatic model_reset();
        m_mode      = M_BOOT;
        m_boot_left = BOOT;
        m_pc        = '0;
        m_pend.delete();
        m_taken     = 1'b0;
    endtask

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_edge();
        int           src;
        logic [W-1:0] tgt;
        src = -1;
        tgt = '0;
        for (int i = 0; i < NR; i++)
            if (src < 0 && redir_valid[i]) src = i;
        if (src >= 0) tgt = redir_addr[src*W +: W];
        m_taken = 1'b0;
        if (m_mode == M_BOOT) begin
            if (m_boot_left == 1) m_mode = M_RUN;
            else m_boot_left--;
        end else if (m_mode == M_RUN) begin
            if (src >= 0 && !stall) begin
                m_pc = tgt; m_pend.delete(); m_taken = 1'b1;
            end else if (src >= 0) begin
                m_pend = {tgt};
            end else if (!stall && m_pend.size() > 0) begin
                m_pc = m_pend.pop_front(); m_taken = 1'b1;
            end else if (!stall && fetch_ready) begin
                m_pc = W'((64'(m_pc) + 64'd1) % (64'd1 << W));
            end
            if (halt_req) m_mode = M_HALT;
        end else begin
            if (resume) begin
                m_mode = M_RUN;
                if (src >= 0) begin
                    m_pc = tgt; m_pend.delete(); m_taken = 1'b1;
                end else if (m_pend.size() > 0) begin
                    m_pc = m_pend.pop_front(); m_taken = 1'b1;
                end
            end else if (src >= 0) begin
                m_pend = {tgt};
            end
        end
    endtask

    // One clock: model follows the edge, outputs are sampled 1 ns later.
    task automatic cycle();
        if (!rst) model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        redir_valid = '0; stall = 0; halt_req = 0; resume = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Jump the main DUT to addr through source 2 (assumes RUN, no stall).
    task automatic go_to(input logic [W-1:0] addr);
        redir_valid = 3'b100;
        redir_addr[2*W +: W] = addr;
        cycle();
        redir_valid = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        model_reset();
        #3;
        if (pc_o !== 32'h0)      begin n_err++; $display("FAIL reset_pc: got %h expected %h", pc_o, 32'h0); end
        if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL reset_fv: got %b expected 0", fetch_valid); end
        if (halted !== 1'b0)      begin n_err++; $display("FAIL reset_halted: got %b expected 0", halted); end
        if (redir_taken !== 1'b0) begin n_err++; $display("FAIL reset_taken: got %b expected 0", redir_taken); end
        n_vec += 4;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_boot();
        logic [W-1:0] exp_pc;
        fetch_ready = 1;
        for (int c = 0; c < BOOT; c++) begin
            if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL boot_fv%0d: got %b expected 0", c, fetch_valid); end
            n_vec++;
            cycle();
        end
        for (int k = 0; k < 4; k++) begin
            exp_pc = W'(k);
            if (pc_o !== exp_pc || fetch_valid !== 1'b1) begin
                n_err++; $display("FAIL boot_seq%0d: got pc=%h fv=%b expected pc=%h fv=1", k, pc_o, fetch_valid, exp_pc);
            end
            n_vec++;
            cycle();
        end
    endtask

    task automatic test_redirect_priority();
        fetch_ready = 1;
        go_to(32'h10);
        redir_valid = 3'b110;
        redir_addr[1*W +: W] = 32'h100;
        redir_addr[2*W +: W] = 32'h200;
        cycle();
        if (pc_o !== 32'h100 || redir_taken !== 1'b1) begin
            n_err++; $display("FAIL prio_load: got pc=%h taken=%b expected pc=00000100 taken=1", pc_o, redir_taken);
        end
        n_vec++;
        redir_valid = '0;
        cycle();
        if (pc_o !== 32'h101 || redir_taken !== 1'b0) begin
            n_err++; $display("FAIL prio_next: got pc=%h taken=%b expected pc=00000101 taken=0", pc_o, redir_taken);
        end
        n_vec++;
    endtask

    task automatic test_stall_pending();
        fetch_ready = 1;
        go_to(32'h20);
        stall = 1;
        redir_valid = 3'b100; redir_addr[2*W +: W] = 32'h300;
        cycle();
        if (pc_o !== 32'h20) begin n_err++; $display("FAIL stall_a: got %h expected 00000020", pc_o); end
        redir_valid = 3'b010; redir_addr[1*W +: W] = 32'h400;
        cycle();
        if (pc_o !== 32'h20) begin n_err++; $display("FAIL stall_b: got %h expected 00000020", pc_o); end
        redir_valid = '0; stall = 0;
        cycle();
        if (pc_o !== 32'h400 || redir_taken !== 1'b1) begin
            n_err++; $display("FAIL stall_release: got pc=%h taken=%b expected pc=00000400 taken=1", pc_o, redir_taken);
        end
        cycle();
        if (pc_o !== 32'h401 || redir_taken !== 1'b0) begin
            n_err++; $display("FAIL stall_after: got pc=%h taken=%b expected pc=00000401 taken=0", pc_o, redir_taken);
        end
        n_vec += 4;
    endtask

    task automatic test_ready_hold();
        fetch_ready = 1;
        go_to(32'h40);
        fetch_ready = 0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            if (pc_o !== 32'h40 || fetch_valid !== 1'b1) begin
                n_err++; $display("FAIL hold%0d: got pc=%h fv=%b expected pc=00000040 fv=1", c, pc_o, fetch_valid);
            end
            n_vec++;
        end
        fetch_ready = 1;
        cycle();
        if (pc_o !== 32'h41) begin n_err++; $display("FAIL hold_accept: got %h expected 00000041", pc_o); end
        n_vec++;
    endtask

    task automatic test_back_to_back();
        fetch_ready = 0;
        redir_valid = 3'b010; redir_addr[1*W +: W] = 32'h111;
        cycle();
        if (pc_o !== 32'h111 || redir_taken !== 1'b1) begin
            n_err++; $display("FAIL b2b_first: got pc=%h taken=%b expected pc=00000111 taken=1", pc_o, redir_taken);
        end
        redir_valid = 3'b101; redir_addr[0 +: W] = 32'h222; redir_addr[2*W +: W] = 32'h333;
        cycle();
        if (pc_o !== 32'h222 || redir_taken !== 1'b1) begin
            n_err++; $display("FAIL b2b_second: got pc=%h taken=%b expected pc=00000222 taken=1", pc_o, redir_taken);
        end
        redir_valid = '0;
        cycle();
        if (pc_o !== 32'h222 || redir_taken !== 1'b0) begin
            n_err++; $display("FAIL b2b_after: got pc=%h taken=%b expected pc=00000222 taken=0", pc_o, redir_taken);
        end
        n_vec += 3;
    endtask

    task automatic test_wrap();
        // dut8 has been in RUN with ready8=0 since the last reset release.
        r8_valid = 3'b001; r8_addr[7:0] = 8'hFC; ready8 = 1;
        cycle();
        if (pc8 !== 8'hFC || taken8 !== 1'b1) begin
            n_err++; $display("FAIL wrap_load: got pc=%h taken=%b expected pc=fc taken=1", pc8, taken8);
        end
        r8_valid = '0;
        cycle();
        if (pc8 !== 8'h00) begin n_err++; $display("FAIL wrap_zero: got %h expected 00", pc8); end
        cycle();
        if (pc8 !== 8'h04) begin n_err++; $display("FAIL wrap_next: got %h expected 04", pc8); end
        n_vec += 3;
        ready8 = 0;
    endtask

    task automatic test_halt();
        fetch_ready = 1;
        go_to(32'h50);
        halt_req = 1;
        cycle();
        if (pc_o !== 32'h51 || halted !== 1'b1 || fetch_valid !== 1'b0) begin
            n_err++; $display("FAIL halt_enter: got pc=%h halted=%b fv=%b expected pc=00000051 halted=1 fv=0", pc_o, halted, fetch_valid);
        end
        halt_req = 0;
        redir_valid = 3'b001; redir_addr[0 +: W] = 32'h800;
        cycle();
        if (pc_o !== 32'h51 || halted !== 1'b1) begin
            n_err++; $display("FAIL halt_capture: got pc=%h halted=%b expected pc=00000051 halted=1", pc_o, halted);
        end
        redir_valid = '0; resume = 1;
        cycle();
        if (pc_o !== 32'h800 || redir_taken !== 1'b1 || fetch_valid !== 1'b1 || halted !== 1'b0) begin
            n_err++; $display("FAIL halt_resume: got pc=%h taken=%b fv=%b halted=%b expected pc=00000800 taken=1 fv=1 halted=0",
                              pc_o, redir_taken, fetch_valid, halted);
        end
        n_vec += 3;
        resume = 0; fetch_ready = 0; halt_req = 1;
        cycle();
        halt_req = 0;
        redir_valid = 3'b001; redir_addr[0 +: W] = 32'h900;
        cycle();
        redir_valid = '0;
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        if (pc_o !== 32'h0 || halted !== 1'b0 || fetch_valid !== 1'b0) begin
            n_err++; $display("FAIL async_reset: got pc=%h halted=%b fv=%b expected pc=00000000 halted=0 fv=0", pc_o, halted, fetch_valid);
        end
        n_vec++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < BOOT + 1; c++) cycle();
        if (pc_o !== 32'h0 || redir_taken !== 1'b0 || fetch_valid !== 1'b1) begin
            n_err++; $display("FAIL pend_lost: got pc=%h taken=%b fv=%b expected pc=00000000 taken=0 fv=1", pc_o, redir_taken, fetch_valid);
        end
        n_vec++;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            redir_valid = ($urandom_range(0, 2) == 0) ? NR'($urandom_range(1, 7)) : '0;
            for (int i = 0; i < NR; i++) redir_addr[i*W +: W] = $urandom;
            stall       = ($urandom_range(0, 3) == 0);
            halt_req    = ($urandom_range(0, 11) == 0);
            resume      = ($urandom_range(0, 3) == 0);
            fetch_ready = ($urandom_range(0, 3) != 0);
            if (c == 200) begin
                // force a wrap of the 32-bit counter under random traffic
                redir_valid = 3'b001; redir_addr[0 +: W] = 32'hFFFF_FFFE; stall = 0;
            end
            cycle();
            if (pc_o !== m_pc || redir_taken !== m_taken ||
                fetch_valid !== (m_mode == M_RUN) || halted !== (m_mode == M_HALT)) begin
                n_err++;
                $display("FAIL rand%0d: got pc=%h taken=%b fv=%b halted=%b expected pc=%h taken=%b fv=%b halted=%b",
                         c, pc_o, redir_taken, fetch_valid, halted,
                         m_pc, m_taken, (m_mode == M_RUN), (m_mode == M_HALT));
            end
            n_vec++;
        end
        clear_inputs();
    endtask

    initial begin
        #2;
        test_reset();
        test_boot();
        test_wrap();
        test_redirect_priority();
        test_stall_pending();
        test_ready_hold();
        test_back_to_back();
        test_halt();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator for the fetch stage. It is the successor of the single-redirect PC register. It adds:
- configurable address width and step;
- N prioritised redirect sources;
- a valid/ready fetch handshake;
- a pending-redirect buffer that holds redirects arriving while stalled or halted;
- a boot/run/halt state machine.

It sits between the control/trap unit and the instruction-memory request port.

Parameters:
ADDR_W, 32, PC width in bits.
RESET_ADDR, 0, PC value on reset (ADDR_W bits).
STEP, 1, sequential increment (1 = word-addressed, 4 = byte-addressed).
NUM_REDIR, 3, number of redirect sources; index 0 has highest priority (trap > branch > jump at default).
BOOT_CYCLES, 2, cycles after reset release before the first fetch is offered (range 1..15).

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
redir_valid  in  NUM_REDIR  per-source redirect request.
redir_addr  in  NUM_REDIR*ADDR_W  redirect targets; source i occupies bits [i*ADDR_W +: ADDR_W].
stall  in  1  pipeline stall: hold PC, no advance.
halt_req  in  1  request to halt fetch (debug).
resume  in  1  leave HALTED.
fetch_ready  in  1  instruction memory accepts the current pc_o.
fetch_valid  out  1  pc_o is a valid fetch request.
pc_o  out  ADDR_W  current fetch address.
redir_taken  out  1  one-cycle pulse: pc_o was loaded from a redirect (direct or pending) on the last edge.
halted  out  1  high while in HALTED.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - pc_o=RESET_ADDR, fetch_valid=0, redir_taken=0, halted=0;
  - pending buffer empty; state=BOOT; boot counter=0.
- Reset asserted mid-operation aborts everything immediately (no synchronising to clk); the pending redirect is discarded.
- Selected redirect (sel) = lowest index i with redir_valid[i]=1. A redirect "exists" this cycle if any bit is set.
- State BOOT:
  - fetch_valid=0; counter increments each cycle.
  - When the counter reaches BOOT_CYCLES-1, go to RUN next edge.
  - Redirect inputs are ignored in BOOT.
- State RUN: fetch_valid=1. Per edge, in priority order:
  1. Redirect exists and stall=0: pc_o<=sel addr, pending cleared, redir_taken=1. This applies even if fetch_ready=0; the unaccepted fetch is dropped.
  2. Redirect exists and stall=1: pending<=sel addr (newest overwrites older pending); pc_o holds.
  3. No redirect, stall=0, pending valid: pc_o<=pending, pending cleared, redir_taken=1.
  4. No redirect, stall=0, fetch_ready=1: pc_o<=pc_o+STEP, modulo 2^ADDR_W (wraps to 0, no flag).
  5. Otherwise pc_o holds. fetch_valid stays 1 and the address is stable until accepted.
- halt_req=1 in RUN:
  - Go to HALTED next edge; the same edge still applies rules 1–5.
  - halted=1 and fetch_valid=0 from the following cycle.
- State HALTED:
  - pc_o holds; redirects are captured into pending (newest wins).
  - resume=1 goes to RUN. On that edge, pending (or a same-cycle redirect, which wins over pending) is loaded into pc_o with redir_taken=1.
  - resume and halt_req both high: resume wins; halt_req is re-evaluated next cycle in RUN.
- redir_taken is registered and high for exactly one cycle per load.
- stall has no effect in BOOT or HALTED.
- halt_req in BOOT is ignored.

Test Plan:
- Reset then release, BOOT_CYCLES=2, fetch_ready=1 → fetch_valid=0 for 2 cycles; then pc_o=0,1,2,3 on consecutive cycles.
- RUN at pc_o=0x10; redir_valid=3'b110 with addr1=0x100, addr2=0x200 → next pc_o=0x100, redir_taken=1 for one cycle, then 0x101.
- stall=1 at pc_o=0x20. Cycle A: redirect src2=0x300. Cycle B: src1=0x400. Release stall with no redirect → pc_o stays 0x20 through stall, then 0x400, redir_taken pulse.
- fetch_ready=0 for 3 cycles at pc_o=0x40 → pc_o=0x40 and fetch_valid=1 held; ready=1 → 0x41.
- ADDR_W=8, STEP=4, pc_o=0xFC, ready=1 → pc_o=0x00.
- halt_req at pc_o=0x50 with ready=1 → pc_o=0x51, then halted=1, fetch_valid=0. Redirect src0=0x800 while halted; resume → pc_o=0x800, redir_taken=1, fetch_valid=1. Assert rst mid-HALTED → immediate pc_o=RESET_ADDR, halted=0, pending lost.
